// File: rtl/snes_nes_pad_bridge.sv
// SNES-to-NES joypad bridge: synchronises and debounces the SNES button vector, adds X/Y turbo
// and SOCD cleaning, and serves it through an NES-style strobe/read shift register.
module snes_nes_pad_bridge #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int TURBO_DIV       = 833333,
    parameter bit SOCD_CLEAN      = 1'b1
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [11:0] BUTTONS,
    input  logic        STROBE,
    input  logic        RD_STB,
    output logic        DOUT,
    output logic [7:0]  PAD_STATE
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW  = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  TURBO_LAST = TW'(TURBO_DIV - 1);

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [11:0]    sync1_q, sync2_q;
    logic [11:0]    cand_q, cand_d;
    logic [11:0]    stable_q, stable_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [TW-1:0]  turbo_cnt_q, turbo_cnt_d;
    logic           phase_q, phase_d;
    logic [7:0]     map_c;
    logic [7:0]     pad_q;
    state_t         state_q, state_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [3:0]     rd_cnt_q, rd_cnt_d;
    logic           dout_q, dout_d;
    logic           up_c, down_c, left_c, right_c;
    logic           nes_a_c, nes_b_c;
    logic           unused_shoulders;

    // TL/TR are carried through sync/debounce but never reach the NES pad.
    assign unused_shoulders = ^stable_q[11:10];

    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q != cand_q) begin
            cand_d   = sync2_q;
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = cand_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        turbo_cnt_d = turbo_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (turbo_cnt_q == TURBO_LAST) begin
            turbo_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        up_c    = stable_q[BTN_UP];
        down_c  = stable_q[BTN_DOWN];
        left_c  = stable_q[BTN_LEFT];
        right_c = stable_q[BTN_RIGHT];
        if (SOCD_CLEAN && up_c && down_c) begin
            up_c   = 1'b0;
            down_c = 1'b0;
        end
        if (SOCD_CLEAN && left_c && right_c) begin
            left_c  = 1'b0;
            right_c = 1'b0;
        end
        nes_a_c = stable_q[BTN_A] | (stable_q[BTN_X] & phase_q);
        nes_b_c = stable_q[BTN_B] | (stable_q[BTN_Y] & phase_q);
        map_c   = {right_c, left_c, down_c, up_c,
                   stable_q[BTN_START], stable_q[BTN_SELECT], nes_b_c, nes_a_c};
    end

    // A strobe always wins over a read pulse; reads shift in 1s so bits 8+ read as pressed.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        rd_cnt_d = rd_cnt_q;
        if (STROBE) begin
            state_d  = ST_LOAD;
            shreg_d  = map_c;
            rd_cnt_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (RD_STB) begin
                        shreg_d  = {1'b1, shreg_q[7:1]};
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        if (rd_cnt_q == 4'd7) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
        dout_d = (rd_cnt_d >= 4'd8) ? 1'b1 : shreg_d[0];
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            stable_q    <= '0;
            db_cnt_q    <= '0;
            turbo_cnt_q <= '0;
            phase_q     <= 1'b0;
            pad_q       <= '0;
            state_q     <= ST_LOAD;
            shreg_q     <= '0;
            rd_cnt_q    <= '0;
            dout_q      <= 1'b0;
        end else begin
            sync1_q     <= BUTTONS;
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            db_cnt_q    <= db_cnt_d;
            turbo_cnt_q <= turbo_cnt_d;
            phase_q     <= phase_d;
            pad_q       <= map_c;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rd_cnt_q    <= rd_cnt_d;
            dout_q      <= dout_d;
        end
    end

    assign DOUT      = dout_q;
    assign PAD_STATE = pad_q;

endmodule
